// File: rtl/keyboard_note_encoder.sv
// keyboard_note_encoder
// Turns PS/2 set-2 scan-code bytes into note-on / note-off events for the
// ALU controller. It keeps track of the currently held note key, so a
// typematic repeat of that key does not retrigger the note, and a release
// of that key produces a note_off strobe.
//
// Optional feature: define OCTAVE_KEYS_EN to let Z (1A) and X (22) step the
// octave down and up. When the macro is undefined, the octave is fixed at
// DEFAULT_OCTAVE and both codes are ignored like any other unmapped byte.
module keyboard_note_encoder #(
  parameter logic [2:0] DEFAULT_OCTAVE = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       note_in,
  output logic [3:0] note,
  output logic [2:0] octave,
  output logic       note_off,
  output logic       held
);

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
`ifdef OCTAVE_KEYS_EN
  localparam logic [7:0] CODE_OCT_DN = 8'h1A;
  localparam logic [7:0] CODE_OCT_UP = 8'h22;
`endif

  // Parser states. BREAK follows F0, EXT follows E0, and EXT_BREAK follows
  // E0 F0. Extended keys are tracked only so that their bytes are swallowed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_e;

  state_e     state_q,     state_d;
  logic       note_in_q,   note_in_d;
  logic       note_off_q,  note_off_d;
  logic [3:0] note_q,      note_d;
  logic       held_q,      held_d;
  logic [7:0] held_code_q, held_code_d;
`ifdef OCTAVE_KEYS_EN
  logic [2:0] octave_q,    octave_d;
`endif

  // Decoded view of the current byte.
  logic       map_hit;
  logic [3:0] map_note;
  logic       is_held_key;

  // Key map: bit 4 flags a mapped note key, bits 3:0 carry the note index.
  function automatic logic [4:0] note_lookup(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h1C:   r = {1'b1, 4'd0};   // A -> C
      8'h1D:   r = {1'b1, 4'd1};   // W -> C#
      8'h1B:   r = {1'b1, 4'd2};   // S -> D
      8'h24:   r = {1'b1, 4'd3};   // E -> D#
      8'h23:   r = {1'b1, 4'd4};   // D -> E
      8'h2B:   r = {1'b1, 4'd5};   // F -> F
      8'h2C:   r = {1'b1, 4'd6};   // T -> F#
      8'h34:   r = {1'b1, 4'd7};   // G -> G
      8'h35:   r = {1'b1, 4'd8};   // Y -> G#
      8'h33:   r = {1'b1, 4'd9};   // H -> A
      8'h3C:   r = {1'b1, 4'd10};  // U -> A#
      8'h3B:   r = {1'b1, 4'd11};  // J -> B
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Byte decode shared by the make and release paths.
  always_comb begin
    map_hit     = 1'b0;
    map_note    = 4'd0;
    is_held_key = 1'b0;
    {map_hit, map_note} = note_lookup(scan_code);
    is_held_key = held_q && (scan_code == held_code_q);
  end

  // Parser next-state and event generation; only a valid byte moves anything.
  always_comb begin
    state_d     = state_q;
    note_in_d   = 1'b0;
    note_off_d  = 1'b0;
    note_d      = note_q;
    held_d      = held_q;
    held_code_d = held_code_q;
`ifdef OCTAVE_KEYS_EN
    octave_d    = octave_q;
`endif
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == CODE_BREAK) begin
            state_d = ST_BREAK;
          end else if (scan_code == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (map_hit) begin
            // A make of the key already held is a typematic repeat.
            if (!is_held_key) begin
              note_d      = map_note;
              note_in_d   = 1'b1;
              held_code_d = scan_code;
              held_d      = 1'b1;
            end
`ifdef OCTAVE_KEYS_EN
          end else if (scan_code == CODE_OCT_DN) begin
            // Repeats keep stepping; saturate at the bottom octave.
            if (octave_q != 3'd0) begin
              octave_d = octave_q - 3'd1;
            end
          end else if (scan_code == CODE_OCT_UP) begin
            if (octave_q != 3'd7) begin
              octave_d = octave_q + 3'd1;
            end
`endif
          end
        end
        ST_BREAK: begin
          if (scan_code == CODE_EXT) begin
            state_d = ST_EXT_BREAK;
          end else if (scan_code == CODE_BREAK) begin
            state_d = ST_BREAK;
          end else begin
            // Only releasing the held key ends the note; others are ignored.
            if (is_held_key) begin
              note_off_d = 1'b1;
              held_d     = 1'b0;
            end
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (scan_code == CODE_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else if (scan_code == CODE_EXT) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset returns the parser to a fresh start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      note_in_q   <= 1'b0;
      note_off_q  <= 1'b0;
      note_q      <= 4'd0;
      held_q      <= 1'b0;
      held_code_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      note_in_q   <= note_in_d;
      note_off_q  <= note_off_d;
      note_q      <= note_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
    end
  end

`ifdef OCTAVE_KEYS_EN
  // Octave register, stepped by the Z / X keys.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      octave_q <= DEFAULT_OCTAVE;
    end else begin
      octave_q <= octave_d;
    end
  end

  assign octave = octave_q;
`else
  assign octave = DEFAULT_OCTAVE;
`endif

  assign note_in  = note_in_q;
  assign note_off = note_off_q;
  assign note     = note_q;
  assign held     = held_q;

endmodule

// File: tb/tb_keyboard_note_encoder.sv
// Directed testbench for keyboard_note_encoder. Bytes are driven at the
// falling edge and outputs are sampled 1 time unit after the rising edge
// that consumed the byte, i.e. in the cycle where the strobes are high.
module tb_keyboard_note_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       note_in;
  logic [3:0] note;
  logic [2:0] octave;
  logic       note_off;
  logic       held;

  int total = 0;
  int bad   = 0;

  // Strobe values seen after the most recent byte, and running counts.
  logic ni_s, no_s;
  int   ni_cnt, no_cnt;

  keyboard_note_encoder #(.DEFAULT_OCTAVE(3'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .note_in    (note_in),
    .note       (note),
    .octave     (octave),
    .note_off   (note_off),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One byte, one cycle; consecutive calls give back-to-back valid bytes.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    ni_s = note_in;
    no_s = note_off;
    if (note_in)  ni_cnt++;
    if (note_off) no_cnt++;
    if (note_in && note_off) chk("strobe_excl", 32'd1, 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    ni_s = note_in;
    no_s = note_off;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    scan_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ni_cnt = 0;
    no_cnt = 0;
  endtask

  logic [7:0] keys [12];

  initial begin
    keys = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
             8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    reset      = 1'b0;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    ni_cnt     = 0;
    no_cnt     = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_note_in",  note_in,  0);
    chk("rst_note_off", note_off, 0);
    chk("rst_note",     note,     0);
    chk("rst_octave",   octave,   4);
    chk("rst_held",     held,     0);
    @(negedge clk);
    reset = 1'b1;

    // Single make
    send(8'h1C);
    chk("make_note_in", ni_s,   1);
    chk("make_note",    note,   0);
    chk("make_octave",  octave, 4);
    chk("make_held",    held,   1);
    idle_cycle();
    chk("make_pulse_len", ni_s, 0);

    // Typematic repeat then release
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    chk("rep_note_in_cnt",  ni_cnt, 1);
    chk("rep_note_off_cnt", no_cnt, 1);
    chk("rep_off_now",      no_s,   1);
    chk("rep_held_after",   held,   0);
    idle_cycle();
    chk("rep_off_len", no_s, 0);

    // Retrigger with a different key; only the newest key releases
    do_reset();
    send(8'h1C);
    chk("rt_ni1",   ni_s, 1);
    chk("rt_note1", note, 0);
    send(8'h3B);
    chk("rt_ni2",   ni_s, 1);
    chk("rt_note2", note, 11);
    send(8'hF0); send(8'h1C);
    chk("rt_old_rel_off",  no_s, 0);
    chk("rt_old_rel_held", held, 1);
    send(8'hF0); send(8'h3B);
    chk("rt_new_rel_off",  no_s, 1);
    chk("rt_new_rel_held", held, 0);
    chk("rt_note_kept",    note, 11);
    chk("rt_off_cnt",      no_cnt, 1);

    // Extended keys and unmapped byte produce nothing
    do_reset();
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    send(8'h15);
    chk("ext_ni_cnt", ni_cnt, 0);
    chk("ext_no_cnt", no_cnt, 0);
    chk("ext_held",   held,   0);
    send(8'h24);
    chk("ext_after_ni",   ni_s, 1);
    chk("ext_after_note", note, 3);

    // Full key map
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(keys[i]);
      chk($sformatf("map_ni_%0d", i),   ni_s, 1);
      chk($sformatf("map_note_%0d", i), note, i);
    end

`ifdef OCTAVE_KEYS_EN
    // Octave keys with saturation at both ends
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h22);
      chk($sformatf("oct_up_%0d", i), octave, ((4 + i + 1) > 7) ? 7 : (4 + i + 1));
    end
    for (int i = 0; i < 9; i++) begin
      send(8'h1A);
      chk($sformatf("oct_dn_%0d", i), octave, ((7 - i - 1) < 0) ? 0 : (7 - i - 1));
    end
    send(8'hF0); send(8'h1A);
    chk("oct_rel_octave", octave, 0);
    chk("oct_ni_cnt", ni_cnt, 0);
    chk("oct_no_cnt", no_cnt, 0);
`else
    // Without octave keys, Z and X are plain unmapped bytes
    do_reset();
    send(8'h22); send(8'h22); send(8'h1A);
    chk("nooct_octave", octave, 4);
    chk("nooct_ni_cnt", ni_cnt, 0);
    chk("nooct_held",   held,   0);
`endif

    // Reset in the middle of a break sequence
    do_reset();
    send(8'h1C);
    send(8'hF0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_held", held, 0);
    chk("mid_rst_note", note, 0);
    @(negedge clk);
    reset = 1'b1;
    send(8'h1C);
    chk("mid_rst_ni",   ni_s, 1);
    chk("mid_rst_off",  no_s, 0);
    chk("mid_rst_note2", note, 0);
    chk("mid_rst_held2", held, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
